uart_rx: RTL and testbench

- UART receiver; the receive-side counterpart of the existing UART transmitter, sharing the same baud-tick generator.
- Recovers 8N1 frames (1 start bit, DATA_BITS data bits LSB first, 1 stop bit) from an asynchronous serial line using a 16x oversampling tick.
- Presents each received byte on a valid/ack holding register.
- Sits between the pad-side RX pin and the host-side consumer (CPU bus interface or FIFO).

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync2.sv | 31 +++
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to TX and RX) and default frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable so idle-high lines stay quiet.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with oversampled mid-bit sampling, valid/ack holding register and sticky error flags.
// Handshake: dataValid stays high from byte completion until a cycle with dataAck=1; a newer byte overwrites.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 clkEn,
  input  logic                 serialInput,
  output logic [DATA_BITS-1:0] outputData,
  output logic                 dataValid,
  input  logic                 dataAck,
  output logic                 frameError,
  output logic                 overrun,
  input  logic                 errClear,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_sync;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rstN),
    .d     (serialInput),
    .q     (rx_sync)
  );

  uart_state_e          state_d, state_q;
  logic [TW-1:0]        tick_d, tick_q;
  logic [BW-1:0]        bit_d, bit_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic [DATA_BITS-1:0] data_d, data_q;
  logic                 prev_d, prev_q;
  logic                 valid_d, valid_q;
  logic                 ferr_d, ferr_q;
  logic                 ovr_d, ovr_q;
  logic                 busy_d, busy_q;
  logic                 byte_done;
  logic                 stop_bad;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    prev_d    = prev_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;

    if (clkEn) begin
      // Previous sample lets IDLE require a real falling edge, so a held-low line cannot re-arm.
      prev_d = rx_sync;
      case (state_q)
        IDLE: begin
          if (prev_q && !rx_sync) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == TICK_HALF) begin
            tick_d = '0;
            bit_d  = '0;
            state_d = rx_sync ? IDLE : DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_q == TICK_FULL) begin
            shift_d = shift_q >> 1;
            shift_d[DATA_BITS-1] = rx_sync;
            tick_d = '0;
            bit_d  = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        STOP: begin
          if (tick_q == TICK_FULL) begin
            tick_d    = '0;
            state_d   = IDLE;
            byte_done = rx_sync;
            stop_bad  = !rx_sync;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    data_d = byte_done ? shift_q : data_q;

    // A completing byte outranks a same-cycle ack; the ack then consumed the old byte, so no overrun.
    valid_d = valid_q;
    if (dataAck)   valid_d = 1'b0;
    if (byte_done) valid_d = 1'b1;

    ovr_d = ovr_q;
    if (errClear)                           ovr_d = 1'b0;
    if (byte_done && valid_q && !dataAck)   ovr_d = 1'b1;

    ferr_d = ferr_q;
    if (errClear) ferr_d = 1'b0;
    if (stop_bad) ferr_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      prev_q  <= 1'b1;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign outputData = data_q;
  assign dataValid  = valid_q;
  assign frameError = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16x oversampling with clkEn every 4 clk, so one bit lasts 64 clk.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rstN;
  logic       clkEn;
  logic       serialInput;
  logic       dataAck;
  logic       errClear;
  logic [7:0] outputData;
  logic       dataValid;
  logic       frameError;
  logic       overrun;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Clock / reset and tick generation
  always #5 clk = ~clk;

  initial begin
    clkEn = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
    end
  end

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .clkEn       (clkEn),
    .serialInput (serialInput),
    .outputData  (outputData),
    .dataValid   (dataValid),
    .dataAck     (dataAck),
    .frameError  (frameError),
    .overrun     (overrun),
    .errClear    (errClear),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic send_bit(input logic v);
    serialInput = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic pulse_ack();
    dataAck = 1'b1;
    @(negedge clk);
    dataAck = 1'b0;
  endtask

  task automatic pulse_clr();
    errClear = 1'b1;
    @(negedge clk);
    errClear = 1'b0;
  endtask

  initial begin
    rstN        = 1'b0;
    serialInput = 1'b1;
    dataAck     = 1'b0;
    errClear    = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data",  outputData, 8'h00);
    check("rst_valid", dataValid,  1'b0);
    check("rst_ferr",  frameError, 1'b0);
    check("rst_ovr",   overrun,    1'b0);
    check("rst_busy",  busy,       1'b0);
    rstN = 1'b1;
    repeat (20) @(negedge clk);

    // Clean frame 0xA5
    send_frame(8'hA5, 1'b1);
    check("a5_data",  outputData, 8'hA5);
    check("a5_valid", dataValid,  1'b1);
    check("a5_ferr",  frameError, 1'b0);
    check("a5_ovr",   overrun,    1'b0);
    check("a5_busy",  busy,       1'b0);
    pulse_ack();
    check("a5_ack_valid", dataValid, 1'b0);

    // Glitch: 5 ticks low, rejected at mid start bit
    serialInput = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy_start", busy, 1'b1);
    serialInput = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_busy_end", busy,       1'b0);
    check("glitch_valid",    dataValid,  1'b0);
    check("glitch_ferr",     frameError, 1'b0);
    check("glitch_ovr",      overrun,    1'b0);

    // Frame 0x3C with bad stop bit
    send_frame(8'h3C, 1'b0);
    serialInput = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check("ferr_flag",  frameError, 1'b1);
    check("ferr_valid", dataValid,  1'b0);
    check("ferr_data",  outputData, 8'hA5);
    check("ferr_busy",  busy,       1'b0);
    pulse_clr();
    check("ferr_clear", frameError, 1'b0);

    // Back-to-back without ack: overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("ovr_data",  outputData, 8'h22);
    check("ovr_valid", dataValid,  1'b1);
    check("ovr_flag",  overrun,    1'b1);
    pulse_clr();
    pulse_ack();
    check("ovr_clear", overrun,   1'b0);
    check("ovr_ack",   dataValid, 1'b0);

    // Back-to-back with ack held through the 0x22 completion cycle
    send_frame(8'h11, 1'b1);
    check("b2b_first", outputData, 8'h11);
    fork
      send_frame(8'h22, 1'b1);
      begin
        int budget;
        repeat (9 * BIT_CLK) @(negedge clk);
        dataAck = 1'b1;
        @(negedge clk);
        check("b2b_old_acked", dataValid, 1'b0);
        budget = 200;
        while (!dataValid && budget > 0) begin
          @(negedge clk);
          budget--;
        end
        dataAck = 1'b0;
        if (budget == 0) check("b2b_ack_timeout", dataValid, 1'b1);
      end
    join
    check("b2b_data",  outputData, 8'h22);
    check("b2b_valid", dataValid,  1'b1);
    check("b2b_ovr",   overrun,    1'b0);
    pulse_ack();

    // Reset in the middle of a 0xFF frame
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5 * BIT_CLK + 32) @(negedge clk);
        check("mid_busy_before", busy, 1'b1);
        rstN = 1'b0;
        #1;
        check("mid_rst_data",  outputData, 8'h00);
        check("mid_rst_valid", dataValid,  1'b0);
        check("mid_rst_busy",  busy,       1'b0);
        check("mid_rst_ferr",  frameError, 1'b0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
      end
    join
    check("mid_after_busy", busy, 1'b0);
    send_frame(8'h5A, 1'b1);
    check("post_rst_data",  outputData, 8'h5A);
    check("post_rst_valid", dataValid,  1'b1);
    check("post_rst_ferr",  frameError, 1'b0);
    pulse_ack();

    // Break: line low for three frame times
    serialInput = 1'b0;
    repeat (700) @(negedge clk);
    check("brk_ferr_once", frameError, 1'b1);
    check("brk_busy_idle", busy,       1'b0);
    pulse_clr();
    repeat (30 * BIT_CLK - 701) @(negedge clk);
    check("brk_no_rearm_ferr", frameError, 1'b0);
    check("brk_no_rearm_busy", busy,       1'b0);
    check("brk_valid",         dataValid,  1'b0);
    serialInput = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    send_frame(8'h81, 1'b1);
    check("brk_next_data",  outputData, 8'h81);
    check("brk_next_valid", dataValid,  1'b1);
    check("brk_next_ferr",  frameError, 1'b0);
    check("brk_next_ovr",   overrun,    1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
